// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared constants for the GPR writeback arbiter: arbitration modes, source IDs
// and the rotation start helper used by the grant logic.
package gpr_wb_arbiter_pkg;

  localparam int WB_ARB_FIXED = 0;
  localparam int WB_ARB_RR    = 1;
  localparam int SRC_IDX_W    = 3;

  typedef enum logic [SRC_IDX_W-1:0] {
    WB_SRC_ALU  = 3'd0,
    WB_SRC_DMEM = 3'd1,
    WB_SRC_IMM  = 3'd2,
    WB_SRC_MDU  = 3'd3
  } wb_src_e;

  // First index examined by the grant search; fixed priority always starts at 0.
  function automatic int rr_start(input int ptr, input int num, input int mode);
    if (mode != WB_ARB_RR) begin
      return 0;
    end else if (ptr + 1 >= num) begin
      return 0;
    end else begin
      return ptr + 1;
    end
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_rr.sv
// Combinational grant selector: picks the held request closest (in rotation
// order) to the search start; one-hot grant plus encoded index.
module gpr_wb_arbiter_rr
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int ARB_MODE = WB_ARB_FIXED
) (
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [SRC_IDX_W-1:0] rr_ptr_i,
  output logic [NUM_SRC-1:0]   gnt_o,
  output logic [SRC_IDX_W-1:0] gnt_idx_o,
  output logic                 gnt_valid_o
);

  int   start_s;
  int   dist_s;
  int   best_s;
  int   win_s;
  logic take_s;

  always_comb begin
    start_s = rr_start(int'(rr_ptr_i), NUM_SRC, ARB_MODE);
    best_s  = NUM_SRC;
    win_s   = NUM_SRC;
    dist_s  = 0;
    take_s  = 1'b0;
    gnt_o   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      dist_s = (i >= start_s) ? (i - start_s) : (i + NUM_SRC - start_s);
      take_s = req_i[i] && (dist_s < best_s);
      best_s = take_s ? dist_s : best_s;
      win_s  = take_s ? i : win_s;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      gnt_o[i] = (i == win_s);
    end
    gnt_valid_o = (win_s < NUM_SRC);
    gnt_idx_o   = (win_s < NUM_SRC) ? SRC_IDX_W'(win_s) : {SRC_IDX_W{1'b0}};
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Merges NUM_SRC writeback producers onto the single GPR write port through
// 1-entry holding slots, with a registered write port and a hazard query.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 4,
  parameter int ARB_MODE = WB_ARB_FIXED
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [SRC_IDX_W-1:0]        rf_wsrc,
  output logic                        busy,
  input  logic [ADDR_W-1:0]           q_addr,
  output logic                        q_pending
);

  logic [NUM_SRC-1:0]   held_q, held_d;
  logic [ADDR_W-1:0]    slot_addr_q [NUM_SRC];
  logic [ADDR_W-1:0]    slot_addr_d [NUM_SRC];
  logic [DATA_W-1:0]    slot_data_q [NUM_SRC];
  logic [DATA_W-1:0]    slot_data_d [NUM_SRC];
  logic [SRC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic                 rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]    rf_wdata_q, rf_wdata_d;
  logic [SRC_IDX_W-1:0] rf_wsrc_q, rf_wsrc_d;

  logic [NUM_SRC-1:0]   gnt_s;
  logic [SRC_IDX_W-1:0] gnt_idx_s;
  logic                 gnt_valid_s;
  logic [NUM_SRC-1:0]   accept_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [DATA_W-1:0]    sel_data_s;
  logic                 hit_s;

  gpr_wb_arbiter_rr #(
    .NUM_SRC  (NUM_SRC),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req_i       (held_q),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_o       (gnt_s),
    .gnt_idx_o   (gnt_idx_s),
    .gnt_valid_o (gnt_valid_s)
  );

  // A slot being drained by this cycle's grant can be refilled in the same cycle.
  assign src_ready = rst ? {NUM_SRC{1'b0}} : (~held_q | gnt_s);
  assign accept_s  = src_valid & src_ready;

  always_comb begin
    held_d     = held_q;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_addr_s     = sel_addr_s | (gnt_s[i] ? slot_addr_q[i] : {ADDR_W{1'b0}});
      sel_data_s     = sel_data_s | (gnt_s[i] ? slot_data_q[i] : {DATA_W{1'b0}});
      // Writes to r0 are handshaken but never become held.
      held_d[i]      = accept_s[i] ? (src_addr[i*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})
                                   : (held_q[i] & ~gnt_s[i]);
      slot_addr_d[i] = accept_s[i] ? src_addr[i*ADDR_W +: ADDR_W] : slot_addr_q[i];
      slot_data_d[i] = accept_s[i] ? src_data[i*DATA_W +: DATA_W] : slot_data_q[i];
    end
    rf_we_d    = gnt_valid_s;
    rf_waddr_d = gnt_valid_s ? sel_addr_s : rf_waddr_q;
    rf_wdata_d = gnt_valid_s ? sel_data_s : rf_wdata_q;
    rf_wsrc_d  = gnt_valid_s ? gnt_idx_s  : rf_wsrc_q;
    rr_ptr_d   = gnt_valid_s ? gnt_idx_s  : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q     <= {NUM_SRC{1'b0}};
      rr_ptr_q   <= SRC_IDX_W'(NUM_SRC - 1);
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {ADDR_W{1'b0}};
      rf_wdata_q <= {DATA_W{1'b0}};
      rf_wsrc_q  <= {SRC_IDX_W{1'b0}};
    end else begin
      held_q     <= held_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_wsrc_q  <= rf_wsrc_d;
    end
  end

  // Slot payload is qualified by held_q, so it needs no reset.
  always_ff @(posedge clk) begin
    slot_addr_q <= slot_addr_d;
    slot_data_q <= slot_data_d;
  end

  always_comb begin
    hit_s = rf_we_q && (rf_waddr_q == q_addr);
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_s = hit_s | (held_q[i] & (slot_addr_q[i] == q_addr));
    end
  end

  assign q_pending = (q_addr != {ADDR_W{1'b0}}) & hit_s;
  assign busy      = (|held_q) | rf_we_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_wsrc   = rf_wsrc_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: a fixed-priority and a round-robin instance share
// the stimulus; a slot-level model is compared every cycle, plus literal pins.
module tb_gpr_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   src_valid;
  logic [19:0]  src_addr;
  logic [127:0] src_data;
  logic [4:0]   q_addr;

  logic [3:0]   d_ready [2];
  logic         d_we    [2];
  logic [4:0]   d_waddr [2];
  logic [31:0]  d_wdata [2];
  logic [2:0]   d_wsrc  [2];
  logic         d_busy  [2];
  logic         d_qp    [2];

  gpr_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_SRC(4), .ARB_MODE(0)) u_fixed (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(d_ready[0]),
    .src_addr(src_addr), .src_data(src_data), .rf_we(d_we[0]), .rf_waddr(d_waddr[0]),
    .rf_wdata(d_wdata[0]), .rf_wsrc(d_wsrc[0]), .busy(d_busy[0]),
    .q_addr(q_addr), .q_pending(d_qp[0]));

  gpr_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_SRC(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(d_ready[1]),
    .src_addr(src_addr), .src_data(src_data), .rf_we(d_we[1]), .rf_waddr(d_waddr[1]),
    .rf_wdata(d_wdata[1]), .rf_wsrc(d_wsrc[1]), .busy(d_busy[1]),
    .q_addr(q_addr), .q_pending(d_qp[1]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: index 0 = fixed priority, 1 = round-robin ----------------
  bit          live = 1'b0;
  bit          mheld [2][4];
  logic [4:0]  maddr [2][4];
  logic [31:0] mdata [2][4];
  int          mptr  [2];
  bit          mwe   [2];
  logic [4:0]  mwaddr[2];
  logic [31:0] mwdata[2];
  int          mwsrc [2];

  function automatic int winner(input int m);
    int start;
    int j;
    start = (m == 1) ? (mptr[m] + 1) % 4 : 0;
    for (int k = 0; k < 4; k++) begin
      j = (start + k) % 4;
      if (mheld[m][j]) return j;
    end
    return -1;
  endfunction

  function automatic bit accepts(input int m, input int i);
    return !rst && (!mheld[m][i] || winner(m) == i);
  endfunction

  function automatic logic [3:0] exp_ready(input int m);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = accepts(m, i);
    return r;
  endfunction

  function automatic bit exp_qp(input int m);
    if (q_addr == 5'd0) return 1'b0;
    if (mwe[m] && mwaddr[m] == q_addr) return 1'b1;
    for (int i = 0; i < 4; i++) if (mheld[m][i] && maddr[m][i] == q_addr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_busy(input int m);
    bit b;
    b = mwe[m];
    for (int i = 0; i < 4; i++) b = b | mheld[m][i];
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst) live <= 1'b1;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) mheld[m][i] <= 1'b0;
        mptr[m] <= 3; mwe[m] <= 1'b0; mwaddr[m] <= 5'd0; mwdata[m] <= 32'd0; mwsrc[m] <= 0;
      end else begin
        mwe[m] <= (winner(m) >= 0);
        for (int i = 0; i < 4; i++) begin
          if (winner(m) == i) begin
            mwaddr[m] <= maddr[m][i]; mwdata[m] <= mdata[m][i];
            mwsrc[m]  <= i;           mptr[m]   <= i;
            mheld[m][i] <= 1'b0;
          end
          if (src_valid[i] && accepts(m, i)) begin
            mheld[m][i] <= (src_addr[i*5 +: 5] != 5'd0);
            maddr[m][i] <= src_addr[i*5 +: 5];
            mdata[m][i] <= src_data[i*32 +: 32];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("dut%0d src_ready", m), d_ready[m], exp_ready(m));
        chk($sformatf("dut%0d rf_we", m),     d_we[m],    mwe[m]);
        chk($sformatf("dut%0d rf_waddr", m),  d_waddr[m], mwaddr[m]);
        chk($sformatf("dut%0d rf_wdata", m),  d_wdata[m], mwdata[m]);
        chk($sformatf("dut%0d rf_wsrc", m),   d_wsrc[m],  mwsrc[m]);
        chk($sformatf("dut%0d busy", m),      d_busy[m],  exp_busy(m));
        chk($sformatf("dut%0d q_pending", m), d_qp[m],    exp_qp(m));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    src_valid[i]       = v;
    src_addr[i*5 +: 5] = a;
    src_data[i*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1; src_valid = 4'hF; src_addr = 20'd0; src_data = 128'd0; q_addr = 5'd0;

    // reset held for two cycles with all sources valid
    step(); step();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset dut%0d ready", m), d_ready[m], 4'h0);
      chk($sformatf("reset dut%0d we", m),    d_we[m],    1'b0);
      chk($sformatf("reset dut%0d busy", m),  d_busy[m],  1'b0);
    end
    rst = 1'b0; src_valid = 4'h0; #1;
    for (int m = 0; m < 2; m++) chk($sformatf("release dut%0d ready", m), d_ready[m], 4'hF);

    // single write from source 1
    set_src(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step(); src_valid = 4'h0;
    for (int m = 0; m < 2; m++) chk($sformatf("single dut%0d we early", m), d_we[m], 1'b0);
    step();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("single dut%0d we", m),    d_we[m],    1'b1);
      chk($sformatf("single dut%0d waddr", m), d_waddr[m], 5'd5);
      chk($sformatf("single dut%0d wdata", m), d_wdata[m], 32'hDEAD_BEEF);
      chk($sformatf("single dut%0d wsrc", m),  d_wsrc[m],  3'd1);
    end
    step();
    for (int m = 0; m < 2; m++) chk($sformatf("single dut%0d we after", m), d_we[m], 1'b0);

    // contention: all four sources at once; rr pointer now sits at 1
    for (int i = 0; i < 4; i++) set_src(i, 1'b1, 5'(i + 1), 32'h1000_0000 + i);
    step(); src_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      chk("contend fixed ready3", d_ready[0][3], (k == 3));
      step();
      chk("contend fixed we",    d_we[0],    1'b1);
      chk("contend fixed waddr", d_waddr[0], 5'(k + 1));
      chk("contend rr wsrc",     d_wsrc[1],  3'((k + 2) % 4));
    end
    step();
    for (int m = 0; m < 2; m++) chk($sformatf("contend dut%0d idle", m), d_busy[m], 1'b0);

    // round-robin under continuous load, starting from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_src(i, 1'b1, 5'(i + 1), 32'h2000_0000 + i);
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr we",         d_we[1],   1'b1);
      chk("rr wsrc",       d_wsrc[1], 3'(k % 4));
      chk("rr fixed wsrc", d_wsrc[0], 3'd0);
    end
    src_valid = 4'h0;
    repeat (6) step();
    for (int m = 0; m < 2; m++) chk($sformatf("rr drain dut%0d busy", m), d_busy[m], 1'b0);

    // write to r0 is accepted and dropped
    set_src(2, 1'b1, 5'd0, 32'h5555_AAAA); #1;
    for (int m = 0; m < 2; m++) chk($sformatf("r0 dut%0d ready2", m), d_ready[m][2], 1'b1);
    step(); src_valid = 4'h0; q_addr = 5'd0; #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("r0 dut%0d busy", m), d_busy[m], 1'b0);
      chk($sformatf("r0 dut%0d qp", m),   d_qp[m],   1'b0);
    end
    repeat (2) begin
      step();
      for (int m = 0; m < 2; m++) chk($sformatf("r0 dut%0d we", m), d_we[m], 1'b0);
    end

    // hazard query on a held entry, then reset before it can be written
    set_src(0, 1'b1, 5'd7,  32'h7777_0000);
    set_src(1, 1'b1, 5'd8,  32'h8888_0000);
    set_src(2, 1'b1, 5'd9,  32'h9999_0000);
    set_src(3, 1'b1, 5'd10, 32'hAAAA_0000);
    step(); src_valid = 4'h0; q_addr = 5'd7; #1;
    for (int m = 0; m < 2; m++) chk($sformatf("hazard dut%0d qp", m), d_qp[m], 1'b1);
    rst = 1'b1; step(); rst = 1'b0; #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("midrst dut%0d qp", m),   d_qp[m],   1'b0);
      chk($sformatf("midrst dut%0d busy", m), d_busy[m], 1'b0);
    end
    repeat (4) begin
      step();
      for (int m = 0; m < 2; m++) chk($sformatf("midrst dut%0d we", m), d_we[m], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
